// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debounce slice.
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO,
        WAIT1,
        ONE,
        WAIT0
    } db_state_t;

    localparam int STABLE_TICKS_DEF = 3;
    localparam int SYNC_STAGES_DEF  = 2;

endpackage

// File: rtl/debounce_fsm_if.sv
// Switch-side bundle: raw input and tick in, clean level and edge pulses out.
interface debounce_fsm_if;

    logic ms10_tick;
    logic sw;
    logic db_level;
    logic db_rise;
    logic db_fall;

    modport master (
        output ms10_tick,
        output sw,
        input  db_level,
        input  db_rise,
        input  db_fall
    );

    modport slave (
        input  ms10_tick,
        input  sw,
        output db_level,
        output db_rise,
        output db_fall
    );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for one asynchronous bit.
module bit_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Tick-counted debounce of one switch with registered level and edge pulses.
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    debounce_fsm_if.slave  db
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    db_state_t     state;
    db_state_t     state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          sw_s;
    logic          level_d;
    logic          rise_d;
    logic          fall_d;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;

    bit_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (db.sw),
        .q      (sw_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ZERO;
            cnt     <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // An abort on sw_s always takes priority over a tick in the same cycle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            ZERO: begin
                if (sw_s) begin
                    state_d = WAIT1;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_d = ZERO;
                end else if (db.ms10_tick) begin
                    if (cnt == CNT_ONE) state_d = ONE;
                    else                cnt_d   = cnt - CNT_ONE;
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_d = WAIT0;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_d = ONE;
                end else if (db.ms10_tick) begin
                    if (cnt == CNT_ONE) state_d = ZERO;
                    else                cnt_d   = cnt - CNT_ONE;
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        level_d = (state_d == ONE) || (state_d == WAIT0);
        rise_d  = (state == WAIT1) && (state_d == ONE);
        fall_d  = (state == WAIT0) && (state_d == ZERO);
    end

    assign db.db_level = level_q;
    assign db.db_rise  = rise_q;
    assign db.db_fall  = fall_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm with STABLE_TICKS=3, SYNC_STAGES=2.
module tb_debounce_fsm;
    import debounce_pkg::*;

    typedef struct {
        logic sw;
        int   ncyc;
        logic level;
        int   rises;
        int   falls;
    } seg_t;

    logic clk = 1'b0;
    logic reset_n;

    int n_tests = 0;
    int n_fail  = 0;
    int ph      = 0;
    int nrise   = 0;
    int nfall   = 0;
    int nlow    = 0;
    int nboth   = 0;
    int ncyc    = 0;

    seg_t segs[9];

    debounce_fsm_if dif ();

    debounce_fsm #(
        .STABLE_TICKS(3),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .db     (dif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        nrise = 0;
        nfall = 0;
        nlow  = 0;
        ncyc  = 0;
    endtask

    // Drive one cycle, then sample the registered outputs 1 ns after the edge.
    task automatic cyc(input logic s, input logic t);
        dif.sw        = s;
        dif.ms10_tick = t;
        @(posedge clk);
        #1;
        ncyc++;
        if (dif.db_rise)  nrise++;
        if (dif.db_fall)  nfall++;
        if (!dif.db_level) nlow++;
        if (dif.db_rise && dif.db_fall) nboth++;
    endtask

    task automatic auto_cyc(input logic s);
        logic t;
        t  = (ph == 7);
        ph = (ph + 1) % 8;
        cyc(s, t);
    endtask

    // Edge held for 30 cycles from tick phase 0: ticks land on cycles 7, 15, 23.
    task automatic edge_seq(input logic s, input string tag);
        int   at;
        logic lvl22;
        at    = -1;
        lvl22 = 1'bx;
        ph    = 0;
        clr();
        for (int i = 0; i < 30; i++) begin
            auto_cyc(s);
            if (s ? dif.db_rise : dif.db_fall) at = i;
            if (i == 22) lvl22 = dif.db_level;
        end
        check({tag, "_pulse_cycle"}, at, 23);
        check({tag, "_pulses"}, s ? nrise : nfall, 1);
        check({tag, "_other_pulses"}, s ? nfall : nrise, 0);
        check({tag, "_level_before"}, int'(lvl22), int'(!s));
        check({tag, "_level_after"}, int'(dif.db_level), int'(s));
    endtask

    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, "_level"}, int'(dif.db_level), 0);
        check({tag, "_rise"}, int'(dif.db_rise), 0);
        check({tag, "_fall"}, int'(dif.db_fall), 0);
        check({tag, "_state"}, int'(dut.state), int'(ZERO));
        check({tag, "_cnt"}, int'(dut.cnt), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int at;

        segs[0] = '{1'b0, 100, 1'b0, 0, 0};
        segs[1] = '{1'b1,  40, 1'b1, 1, 0};
        segs[2] = '{1'b1,  20, 1'b1, 0, 0};
        segs[3] = '{1'b0,  40, 1'b0, 0, 1};
        segs[4] = '{1'b1,   5, 1'b0, 0, 0};
        segs[5] = '{1'b0,  20, 1'b0, 0, 0};
        segs[6] = '{1'b1,  40, 1'b1, 1, 0};
        segs[7] = '{1'b0,   6, 1'b1, 0, 0};
        segs[8] = '{1'b1,  20, 1'b1, 0, 0};

        reset_n       = 1'b0;
        dif.sw        = 1'b0;
        dif.ms10_tick = 1'b0;
        @(posedge clk);
        #1;
        check("rst_level", int'(dif.db_level), 0);
        check("rst_rise", int'(dif.db_rise), 0);
        check("rst_fall", int'(dif.db_fall), 0);
        check("rst_state", int'(dut.state), int'(ZERO));
        reset_n = 1'b1;

        for (int k = 0; k < 9; k++) begin
            clr();
            for (int j = 0; j < segs[k].ncyc; j++) auto_cyc(segs[k].sw);
            check($sformatf("seg%0d_level", k), int'(dif.db_level), int'(segs[k].level));
            check($sformatf("seg%0d_rises", k), nrise, segs[k].rises);
            check($sformatf("seg%0d_falls", k), nfall, segs[k].falls);
            if (k == 0) check("idle_low_cycles", nlow, 100);
        end

        // Short release glitch spanning one tick must not drop the level.
        ph = 0;
        clr();
        for (int i = 0; i < 30; i++) auto_cyc(i < 10 ? 1'b0 : 1'b1);
        check("glitch_falls", nfall, 0);
        check("glitch_low_cycles", nlow, 0);

        edge_seq(1'b0, "release");
        edge_seq(1'b1, "press");
        edge_seq(1'b0, "release2");

        // Bounce 1,0,1,0 at 3-clk intervals, then hold 1 from cycle 12.
        ph = 0;
        at = -1;
        clr();
        for (int i = 0; i < 40; i++) begin
            auto_cyc(i < 12 ? logic'(((i / 3) % 2) == 0) : 1'b1);
            if (dif.db_rise) at = i;
        end
        check("bounce_rise_cycle", at, 31);
        check("bounce_rises", nrise, 1);
        check("bounce_falls", nfall, 0);

        check("pre_rst_one_level", int'(dif.db_level), 1);
        dif.sw = 1'b0;
        async_reset("rst_from_one");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);

        // WAIT1 with cnt=1 sees the abort and a tick on the same edge.
        clr();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        check("simul_pre_state", int'(dut.state), int'(WAIT1));
        check("simul_pre_cnt", int'(dut.cnt), 1);
        cyc(1'b0, 1'b1);
        check("simul_state", int'(dut.state), int'(ZERO));
        check("simul_level", int'(dif.db_level), 0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0);
        check("simul_rises", nrise, 0);
        check("simul_low_cycles", nlow, ncyc);

        // Reset while in WAIT1 with cnt=2, sw kept high across release.
        ph = 0;
        for (int i = 0; i < 10; i++) auto_cyc(1'b1);
        check("wait1_state", int'(dut.state), int'(WAIT1));
        check("wait1_cnt", int'(dut.cnt), 2);
        async_reset("rst_in_wait1");
        edge_seq(1'b1, "post_rst_press");

        check("rise_fall_overlap", nboth, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
